adc_sample_averager: RTL and testbench
======================================

# adc_sample_averager

Streaming consumer placed directly downstream of the modular ADC sequencer response port. It accepts one 12-bit sample per cycle, accumulates 2^LOG2_AVG samples per channel, and publishes the truncated mean per channel. Results are exposed through a 16-bit Avalon-MM slave that hangs off the MM bridge master side. Also provides a drop counter for out-of-range channel tags and an optional per-channel peak tracker.

## Interface
- NUM_CH, 8: number of averaged channels. ADC tags 1..NUM_CH map to index 0..NUM_CH-1.
- LOG2_AVG, 4: log2 of the window length, range 1..4.
- DATA_W, 12: sample width.
- clk_clk  in  1  single clock for the stream and the MM slave.
- reset_reset_n  in  1  synchronous, active-low reset.
- rsp_valid  in  1  sample strobe from the ADC response stream.
- rsp_channel  in  5  channel tag.
- rsp_data  in  DATA_W  unsigned sample.
- avs_address  in  5  word address.
- avs_read / avs_write  in  1  MM strobes.
- avs_writedata  in  16  write data.
- avs_readdata  out  16  read data.
- avs_readdatavalid  out  1  read response strobe.
- avs_waitrequest  out  1  tied 0.

## Operation
- Stage 1 registers valid, index and data.
  - A tag of 0 or a tag above NUM_CH is a drop: it increments drop_cnt, which saturates at 0xFFFF.
  - With ctrl.enable=0, samples are discarded and are not counted as drops.
- Stage 2 does a read-modify-write on acc[idx] (DATA_W+LOG2_AVG bits) and cnt[idx] (LOG2_AVG bits).
  - Normal sample: acc += data, cnt += 1.
  - When cnt == 2^LOG2_AVG-1: result[idx] <= (acc+data) >> LOG2_AVG (truncating), acc <= 0, cnt <= 0 (wrap), fresh[idx] <= 1.
- Back-to-back samples on the same channel are handled without hazard, because the RMW happens in a single stage.
- Register map (word addresses):
  - 0..NUM_CH-1: result[i], zero-extended. Reading clears fresh[i].
  - 8: status. fresh[NUM_CH-1:0] in the low bits.
  - 9: drop_cnt.
  - 10: ctrl.
    - bit0 enable: R/W, reset value 1.
    - bit1 clear: write-1, self-clearing, reads 0.
  - Unmapped addresses read 0. Writes to read-only addresses are ignored.
- Clear:
  - Zeroes acc, cnt, result, fresh, drop_cnt and the peaks on the edge following the write.
  - Flushes the stage-1 sample.
  - A sample in stage 2 on the same edge as the clear is discarded. Clear wins.
- Same-edge conflicts:
  - A read of result[i] on the edge where result[i] updates returns the old value, and fresh[i] ends at 1 (set wins).
  - A read of drop_cnt coinciding with an increment returns the pre-increment value.

## Timing
- Reset values:
  - avs_readdata = 0, avs_readdatavalid = 0, avs_waitrequest = 0.
  - All accumulators, counts, results, fresh bits, drop_cnt and peaks are 0. enable = 1.
- Reset asserted mid-window discards partial accumulation. The first window after reset needs a full 2^LOG2_AVG samples.
- Sample latency: a final sample with rsp_valid high at edge k appears in result and fresh after edge k+2 (two-stage pipeline).
- Read latency is fixed at one cycle.
  - avs_read at edge k produces avs_readdatavalid high for exactly one cycle after edge k+1, with the data.
  - One read per cycle is accepted. No bursts.
- Writes take effect at the accepting edge. Clear acts one edge later.

## Configuration
- ADC_AVG_PEAK_EN defined:
  - Adds peak[i] = max raw sample seen since the last read or clear.
  - Readable at address 16+i. The read returns the peak and zeroes it.
  - A sample arriving on the read edge is included in the new peak.
- ADC_AVG_PEAK_EN undefined:
  - No peak registers are built.
  - Addresses 16..16+NUM_CH-1 read 0.

## Structure
- Package adc_avg_pkg holds:
  - Address constants ADDR_RESULT0, ADDR_STATUS, ADDR_DROP, ADDR_CTRL, ADDR_PEAK0.
  - CTRL_ENABLE_BIT and CTRL_CLEAR_BIT.
  - Default widths.
- Sub-module adc_avg_csr holds the Avalon decode, the read mux, the readdatavalid register and the ctrl register.
- The accumulator arrays stay in the top level.

## Test plan
All scenarios use LOG2_AVG=4.
- 16 samples on channel 1 with data 0x800 -> status reads 0x0001, address 0 reads 0x0800 with readdatavalid one cycle after the read, then status reads 0x0000.
- Ramp 0..15 on channel 3, back-to-back -> result[2] = 0x0007, visible two cycles after the 16th valid.
- Tags 0, 9 and 31, one sample each -> drop_cnt = 3 and no result or fresh change. 65540 drops -> drop_cnt = 0xFFFF.
- 8 samples of 0x100 on channel 2, write ctrl = 0x3, then 16 samples of 0xFFF -> result[1] = 0x0FFF with no stale contribution. ctrl reads 0x0001.
- Reset pulled low after 10 samples on channel 4, then 16 samples of 0x010 -> result[3] = 0x0010 and fresh set only after the 16th.
- With ADC_AVG_PEAK_EN: channel 2 samples 0x010, 0xABC, 0x020 -> address 17 reads 0x0ABC, then reads 0x0000. Without the macro, address 17 reads 0x0000.

Source files
------------

// File: rtl/adc_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_avg_pkg
// Brief    : Shared widths, register map and helpers for the ADC averager.
// Revision : 1.0
// ============================================================================
package adc_avg_pkg;

    localparam int NUM_CH_DEF   = 8;
    localparam int LOG2_AVG_DEF = 4;
    localparam int DATA_W_DEF   = 12;
    localparam int TAG_W        = 5;
    localparam int ADDR_W       = 5;
    localparam int MM_W         = 16;

    localparam logic [ADDR_W-1:0] ADDR_RESULT0 = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 5'd8;
    localparam logic [ADDR_W-1:0] ADDR_DROP    = 5'd9;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 5'd10;
    localparam logic [ADDR_W-1:0] ADDR_PEAK0   = 5'd16;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    // ADC tags are 1-based; 0 and anything above num_ch are not channels.
    function automatic logic tag_valid(input logic [TAG_W-1:0] tag, input int num_ch);
        return (tag != '0) && (int'(tag) <= num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_averager_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_averager_if
// Brief    : ADC response stream plus Avalon-MM slave signals of the averager.
// Revision : 1.0
// ============================================================================
interface adc_sample_averager_if
    import adc_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              rsp_valid;
    logic [TAG_W-1:0]  rsp_channel;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [MM_W-1:0]   avs_writedata;
    logic [MM_W-1:0]   avs_readdata;
    logic              avs_readdatavalid;
    logic              avs_waitrequest;

    modport master (
        output rsp_valid, rsp_channel, rsp_data,
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport slave (
        input  rsp_valid, rsp_channel, rsp_data,
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/adc_avg_csr.sv
`default_nettype none
// ============================================================================
// Module   : adc_avg_csr
// Brief    : Avalon-MM decode, read mux and ctrl register of the averager.
//            ADC_AVG_PEAK_EN adds the peak read window.
// Revision : 1.0
// ============================================================================
module adc_avg_csr
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    adc_sample_averager_if.slave bus,
    input  logic [DATA_W-1:0] result [NUM_CH],
    input  logic [NUM_CH-1:0] fresh,
    input  logic [MM_W-1:0]   drop_cnt,
`ifdef ADC_AVG_PEAK_EN
    input  logic [DATA_W-1:0] peak [NUM_CH],
    output logic [NUM_CH-1:0] peak_rd,
`endif
    output logic [NUM_CH-1:0] result_rd,
    output logic              enable,
    output logic              clear
);

    logic [MM_W-1:0] w_rdata;
    logic [MM_W-1:0] r_rdata;
    logic            r_rvalid;
    logic            r_enable;
    logic            r_clear;
    logic            w_unused;

    assign w_unused = &{1'b0, bus.avs_writedata[MM_W-1:2]};

    always_comb begin
        w_rdata   = '0;
        result_rd = '0;
`ifdef ADC_AVG_PEAK_EN
        peak_rd   = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.avs_address == ADDR_RESULT0 + ADDR_W'(i)) begin
                w_rdata      = MM_W'(result[i]);
                result_rd[i] = bus.avs_read;
            end
`ifdef ADC_AVG_PEAK_EN
            if (bus.avs_address == ADDR_PEAK0 + ADDR_W'(i)) begin
                w_rdata    = MM_W'(peak[i]);
                peak_rd[i] = bus.avs_read;
            end
`endif
        end
        if (bus.avs_address == ADDR_STATUS) w_rdata = MM_W'(fresh);
        if (bus.avs_address == ADDR_DROP)   w_rdata = drop_cnt;
        if (bus.avs_address == ADDR_CTRL)   w_rdata[CTRL_ENABLE_BIT] = r_enable;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_enable <= 1'b1;
            r_clear  <= 1'b0;
        end else begin
            r_rvalid <= bus.avs_read;
            if (bus.avs_read) r_rdata <= w_rdata;
            // Clear is a one-edge pulse; the datapath acts on it at the next edge.
            r_clear <= 1'b0;
            if (bus.avs_write && bus.avs_address == ADDR_CTRL) begin
                r_enable <= bus.avs_writedata[CTRL_ENABLE_BIT];
                r_clear  <= bus.avs_writedata[CTRL_CLEAR_BIT];
            end
        end
    end

    assign bus.avs_readdata      = r_rdata;
    assign bus.avs_readdatavalid = r_rvalid;
    assign bus.avs_waitrequest   = 1'b0;
    assign enable                = r_enable;
    assign clear                 = r_clear;

endmodule
`default_nettype wire

// File: rtl/adc_sample_averager.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_averager
// Brief    : Per-channel windowed mean of ADC samples with Avalon-MM readout.
//            Define ADC_AVG_PEAK_EN to build per-channel peak trackers.
// Revision : 1.0
// ============================================================================
module adc_sample_averager
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int LOG2_AVG = LOG2_AVG_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    adc_sample_averager_if.slave bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_W + LOG2_AVG;

    logic              r_s1_valid;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [DATA_W-1:0] r_s1_data;

    logic [ACC_W-1:0]    r_acc    [NUM_CH];
    logic [LOG2_AVG-1:0] r_cnt    [NUM_CH];
    logic [DATA_W-1:0]   r_result [NUM_CH];
    logic [NUM_CH-1:0]   r_fresh;
    logic [MM_W-1:0]     r_drop_cnt;

    logic              w_enable;
    logic              w_clear;
    logic [NUM_CH-1:0] w_result_rd;
    logic              w_take;
    logic              w_tag_ok;
    logic [IDX_W-1:0]  w_idx;
    logic [ACC_W-1:0]  w_sum;
    logic              w_wrap;

    assign w_take   = bus.rsp_valid && w_enable;
    assign w_tag_ok = tag_valid(bus.rsp_channel, NUM_CH);
    assign w_idx    = IDX_W'(bus.rsp_channel - TAG_W'(1));
    assign w_sum    = r_acc[r_s1_idx] + ACC_W'(r_s1_data);
    assign w_wrap   = (r_cnt[r_s1_idx] == '1);

`ifdef ADC_AVG_PEAK_EN
    logic [DATA_W-1:0] r_peak [NUM_CH];
    logic [NUM_CH-1:0] w_peak_rd;
`endif

    adc_avg_csr #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_csr (
        .clk       (clk_clk),
        .reset_n   (reset_reset_n),
        .bus       (bus),
        .result    (r_result),
        .fresh     (r_fresh),
        .drop_cnt  (r_drop_cnt),
`ifdef ADC_AVG_PEAK_EN
        .peak      (r_peak),
        .peak_rd   (w_peak_rd),
`endif
        .result_rd (w_result_rd),
        .enable    (w_enable),
        .clear     (w_clear)
    );

    // Stage 1: register in-range samples, count drops.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_take && w_tag_ok && !w_clear;
            r_s1_idx   <= w_idx;
            r_s1_data  <= bus.rsp_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || w_clear) begin
            r_drop_cnt <= '0;
        end else if (w_take && !w_tag_ok && r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + MM_W'(1);
        end
    end

    // Stage 2: single-cycle read-modify-write, so same-channel back-to-back is safe.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || w_clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]    <= '0;
                r_cnt[i]    <= '0;
                r_result[i] <= '0;
            end
            r_fresh <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_result_rd[i]) r_fresh[i] <= 1'b0;
            end
            if (r_s1_valid) begin
                if (w_wrap) begin
                    r_result[r_s1_idx] <= w_sum[ACC_W-1:LOG2_AVG];
                    r_acc[r_s1_idx]    <= '0;
                    r_cnt[r_s1_idx]    <= '0;
                    r_fresh[r_s1_idx]  <= 1'b1;
                end else begin
                    r_acc[r_s1_idx]    <= w_sum;
                    r_cnt[r_s1_idx]    <= r_cnt[r_s1_idx] + LOG2_AVG'(1);
                end
            end
        end
    end

`ifdef ADC_AVG_PEAK_EN
    // A read restarts the peak from the sample landing on the same edge, if any.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || w_clear) begin
            for (int i = 0; i < NUM_CH; i++) r_peak[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_s1_valid && r_s1_idx == IDX_W'(i)) begin
                    if (w_peak_rd[i] || r_s1_data > r_peak[i]) r_peak[i] <= r_s1_data;
                end else if (w_peak_rd[i]) begin
                    r_peak[i] <= '0;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_averager.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_averager
// Brief    : Directed self-checking bench for adc_sample_averager (LOG2_AVG=4).
// Revision : 1.0
// ============================================================================
module tb_adc_sample_averager;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adc_sample_averager_if #(.DATA_W(12)) bus ();

    adc_sample_averager #(
        .NUM_CH   (8),
        .LOG2_AVG (4),
        .DATA_W   (12)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] ch, input logic [11:0] d);
        bus.rsp_valid   = 1'b1;
        bus.rsp_channel = ch;
        bus.rsp_data    = d;
        tick();
        bus.rsp_valid   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string tag);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        tick();
        bus.avs_read    = 1'b0;
        chk({tag, "_rdv"}, 16'(bus.avs_readdatavalid), 16'h0001);
        chk(tag, bus.avs_readdata, exp);
        tick();
        chk({tag, "_rdv_low"}, 16'(bus.avs_readdatavalid), 16'h0000);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_channel   = '0;
        bus.rsp_data      = '0;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        repeat (3) tick();
        chk("rst_readdata", bus.avs_readdata, 16'h0000);
        chk("rst_rdvalid", 16'(bus.avs_readdatavalid), 16'h0000);
        chk("rst_waitreq", 16'(bus.avs_waitrequest), 16'h0000);
        rst_n = 1'b1;
        tick();
        rd(5'd10, 16'h0001, "rst_ctrl");
        rd(5'd9, 16'h0000, "rst_drop");

        // Window of 16 x 0x800 on channel 1
        for (int i = 0; i < 16; i++) send(5'd1, 12'h800);
        tick();
        rd(5'd8, 16'h0001, "t1_status");
        rd(5'd0, 16'h0800, "t1_result0");
        rd(5'd8, 16'h0000, "t1_status_clr");

        // Ramp on channel 3; first read lands on the update edge
        for (int i = 0; i < 16; i++) send(5'd3, 12'(i));
        rd(5'd2, 16'h0000, "t2_result2_old");
        rd(5'd8, 16'h0004, "t2_status_setwins");
        rd(5'd2, 16'h0007, "t2_result2");

        // Out-of-range tags
        send(5'd0, 12'h111);
        send(5'd9, 12'h222);
        send(5'd31, 12'h333);
        tick();
        tick();
        rd(5'd9, 16'h0003, "t3_drop");
        rd(5'd8, 16'h0000, "t3_status");
        rd(5'd2, 16'h0007, "t3_result2");
        bus.rsp_valid   = 1'b1;
        bus.rsp_channel = 5'd0;
        bus.avs_address = 5'd9;
        bus.avs_read    = 1'b1;
        tick();
        bus.rsp_valid   = 1'b0;
        bus.avs_read    = 1'b0;
        chk("t3_drop_same_edge", bus.avs_readdata, 16'h0003);
        rd(5'd9, 16'h0004, "t3_drop_after");
        bus.rsp_valid   = 1'b1;
        bus.rsp_channel = 5'd0;
        repeat (65540) tick();
        bus.rsp_valid   = 1'b0;
        rd(5'd9, 16'hFFFF, "t3_drop_sat");

        // Partial window then clear
        for (int i = 0; i < 8; i++) send(5'd2, 12'h100);
        wr(5'd10, 16'h0003);
        tick();
        for (int i = 0; i < 16; i++) send(5'd2, 12'hFFF);
        tick();
        rd(5'd8, 16'h0002, "t4_status");
        rd(5'd1, 16'h0FFF, "t4_result1");
        rd(5'd10, 16'h0001, "t4_ctrl");
        rd(5'd9, 16'h0000, "t4_drop_cleared");
        rd(5'd0, 16'h0000, "t4_result0_cleared");

        // Disabled: samples and bad tags ignored
        wr(5'd10, 16'h0000);
        for (int i = 0; i < 16; i++) send(5'd5, 12'h123);
        send(5'd0, 12'h000);
        tick();
        tick();
        rd(5'd8, 16'h0000, "t4_dis_status");
        rd(5'd9, 16'h0000, "t4_dis_drop");
        rd(5'd10, 16'h0000, "t4_dis_ctrl");
        wr(5'd10, 16'h0001);
        for (int i = 0; i < 16; i++) send(5'd5, 12'h040);
        tick();
        rd(5'd8, 16'h0010, "t4_en_status");
        rd(5'd4, 16'h0040, "t4_en_result4");

        // Reset mid-window on channel 4
        for (int i = 0; i < 10; i++) send(5'd4, 12'h3FF);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rd(5'd10, 16'h0001, "t5_ctrl");
        rd(5'd4, 16'h0000, "t5_result4_rst");
        for (int i = 0; i < 15; i++) send(5'd4, 12'h010);
        tick();
        rd(5'd8, 16'h0000, "t5_status_15");
        send(5'd4, 12'h010);
        tick();
        rd(5'd8, 16'h0008, "t5_status_16");
        rd(5'd3, 16'h0010, "t5_result3");

        // Peak window, unmapped and read-only addresses
        send(5'd2, 12'h010);
        send(5'd2, 12'hABC);
        send(5'd2, 12'h020);
        tick();
        tick();
`ifdef ADC_AVG_PEAK_EN
        rd(5'd17, 16'h0ABC, "t6_peak1");
        rd(5'd17, 16'h0000, "t6_peak1_zeroed");
`else
        rd(5'd17, 16'h0000, "t6_peak1_absent");
`endif
        rd(5'd11, 16'h0000, "t6_unmapped");
        wr(5'd9, 16'h1234);
        rd(5'd9, 16'h0000, "t6_ro_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
